sha1_channel_sched: RTL and testbench

- Allocates SHA1 calculation channels to incoming messages and reclaims them when their digests complete.
- Sits between the 128-to-512 message fill controller and the SHA1 calculation top. Replaces a bare FIFO of free channel numbers with a round-robin free-list scheduler.
- Stores the message tag per channel and returns it on release so results can be ordered.

---
 rtl/sha1_channel_sched.sv | 179 +++++++++++++++++
 tb/tb_sha1_channel_sched.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sha1_channel_sched.sv
// sha1_channel_sched
//   Round-robin free-list scheduler for SHA1 calculation channels. Hands out
//   a free channel to each accepted message, remembers the message tag per
//   channel, and returns that tag when the channel is released.
//
// Ports
//   sys_clk, sys_rst    clock, synchronous active-high reset
//   alloc_req/alloc_tag request a channel for a message with this tag
//   alloc_ready         a request is accepted this cycle when asserted
//   alloc_gnt/alloc_ch  one-cycle grant pulse and the granted channel
//   rel_val/rel_ch      release a busy channel
//   rel_tag_val/rel_tag one-cycle pulse with the tag stored for it
//   free_cnt            number of free channels
//   err_double_free     sticky: release of a free or nonexistent channel
module sha1_channel_sched #(
    parameter int CHANNEL_NUM_TOTAL = 64,
    parameter int CHANNEL_NUM_WIDTH = $clog2(CHANNEL_NUM_TOTAL),
    parameter int TAG_DATA_WIDTH    = 14,
    parameter int CNT_WIDTH         = $clog2(CHANNEL_NUM_TOTAL + 1)
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst,
    input  logic                         alloc_req,
    input  logic [TAG_DATA_WIDTH-1:0]    alloc_tag,
    output logic                         alloc_ready,
    output logic                         alloc_gnt,
    output logic [CHANNEL_NUM_WIDTH-1:0] alloc_ch,
    input  logic                         rel_val,
    input  logic [CHANNEL_NUM_WIDTH-1:0] rel_ch,
    output logic                         rel_tag_val,
    output logic [TAG_DATA_WIDTH-1:0]    rel_tag,
    output logic [CNT_WIDTH-1:0]         free_cnt,
    output logic                         err_double_free
);

    typedef enum logic {INIT, RUN} state_e;

    state_e                         state_q, state_d;
    logic [CHANNEL_NUM_WIDTH-1:0]   init_cnt_q;
    logic [CHANNEL_NUM_TOTAL-1:0]   bitmap_q;       // 1 = channel free
    logic [CHANNEL_NUM_WIDTH-1:0]   rr_ptr_q;
    logic [CNT_WIDTH-1:0]           free_cnt_q;
    logic                           alloc_gnt_q;
    logic [CHANNEL_NUM_WIDTH-1:0]   alloc_ch_q;
    logic                           rel_tag_val_q;
    logic [TAG_DATA_WIDTH-1:0]      rel_tag_q;
    logic                           err_q;
    logic [TAG_DATA_WIDTH-1:0]      tag_mem [CHANNEL_NUM_TOTAL];

    logic                           in_init;
    logic                           init_last;
    logic                           sel_found;
    logic [CHANNEL_NUM_WIDTH-1:0]   sel_ch;
    logic                           accept;
    logic                           rel_in_range;
    logic                           rel_ok;
    logic                           rel_bad;

    // (base + off) mod CHANNEL_NUM_TOTAL, valid for base, off < total;
    // one bit of headroom keeps the sum from wrapping at 2**width.
    function automatic logic [CHANNEL_NUM_WIDTH-1:0] wrap_add(
        input logic [CHANNEL_NUM_WIDTH-1:0] base,
        input int unsigned                  off
    );
        logic [CHANNEL_NUM_WIDTH:0] sum;
        sum = {1'b0, base} + (CHANNEL_NUM_WIDTH+1)'(off);
        if (sum >= (CHANNEL_NUM_WIDTH+1)'(CHANNEL_NUM_TOTAL))
            sum = sum - (CHANNEL_NUM_WIDTH+1)'(CHANNEL_NUM_TOTAL);
        return sum[CHANNEL_NUM_WIDTH-1:0];
    endfunction

    // ---------------- FSM: state register ----------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst) state_q <= INIT;
        else         state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:    if (init_last) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_init     = (state_q == INIT);
        alloc_ready = (state_q == RUN) && (free_cnt_q != '0);
    end

    assign init_last = (init_cnt_q == CHANNEL_NUM_WIDTH'(CHANNEL_NUM_TOTAL - 1));

    // Round-robin search over the registered bitmap, so a channel released
    // in the same cycle is only eligible from the next cycle on.
    always_comb begin
        sel_found = 1'b0;
        sel_ch    = '0;
        for (int unsigned i = 0; i < CHANNEL_NUM_TOTAL; i++) begin
            if (!sel_found && bitmap_q[wrap_add(rr_ptr_q, i)]) begin
                sel_found = 1'b1;
                sel_ch    = wrap_add(rr_ptr_q, i);
            end
        end
    end

    generate
        if (CHANNEL_NUM_TOTAL == (1 << CHANNEL_NUM_WIDTH)) begin : g_full_range
            assign rel_in_range = 1'b1;
        end else begin : g_part_range
            assign rel_in_range = (rel_ch < CHANNEL_NUM_WIDTH'(CHANNEL_NUM_TOTAL));
        end
    endgenerate

    assign accept  = alloc_req && alloc_ready && sel_found;
    assign rel_ok  = !in_init && rel_val && rel_in_range && !bitmap_q[rel_ch];
    assign rel_bad = !in_init && rel_val && !(rel_in_range && !bitmap_q[rel_ch]);

    // ---------------- datapath ----------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            init_cnt_q    <= '0;
            bitmap_q      <= '1;
            rr_ptr_q      <= '0;
            free_cnt_q    <= '0;
            alloc_gnt_q   <= 1'b0;
            alloc_ch_q    <= '0;
            rel_tag_val_q <= 1'b0;
            rel_tag_q     <= '0;
            err_q         <= 1'b0;
        end else begin
            alloc_gnt_q   <= 1'b0;
            rel_tag_val_q <= 1'b0;
            if (in_init) begin
                init_cnt_q <= init_cnt_q + 1'b1;
                bitmap_q   <= '1;
                if (init_last)
                    free_cnt_q <= CNT_WIDTH'(CHANNEL_NUM_TOTAL);
            end else begin
                // accept and release always touch different bits: the
                // released channel is busy, the selected one is free
                if (accept) begin
                    bitmap_q[sel_ch] <= 1'b0;
                    alloc_gnt_q      <= 1'b1;
                    alloc_ch_q       <= sel_ch;
                    rr_ptr_q         <= wrap_add(sel_ch, 1);
                end
                if (rel_ok) begin
                    bitmap_q[rel_ch] <= 1'b1;
                    rel_tag_val_q    <= 1'b1;
                    rel_tag_q        <= tag_mem[rel_ch];
                end
                if (rel_bad)
                    err_q <= 1'b1;
                free_cnt_q <= free_cnt_q + CNT_WIDTH'(rel_ok) - CNT_WIDTH'(accept);
            end
        end
    end

    // Tag table: one write port (init clear or alloc), one read port (release)
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            if (in_init)
                tag_mem[init_cnt_q] <= '0;
            else if (accept)
                tag_mem[sel_ch] <= alloc_tag;
        end
    end

    assign alloc_gnt       = alloc_gnt_q;
    assign alloc_ch        = alloc_ch_q;
    assign rel_tag_val     = rel_tag_val_q;
    assign rel_tag         = rel_tag_q;
    assign free_cnt        = free_cnt_q;
    assign err_double_free = err_q;

endmodule

// File: tb/tb_sha1_channel_sched.sv
module tb_sha1_channel_sched;

    localparam int N  = 64;
    localparam int W  = 6;
    localparam int TW = 14;
    localparam int CW = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic [TW-1:0] tag;
    logic          ready;
    logic          gnt;
    logic [W-1:0]  ch;
    logic          relv;
    logic [W-1:0]  relch;
    logic          rtv;
    logic [TW-1:0] rtag;
    logic [CW-1:0] fcnt;
    logic          err;

    int checks = 0;
    int errors = 0;

    sha1_channel_sched #(
        .CHANNEL_NUM_TOTAL(N),
        .CHANNEL_NUM_WIDTH(W),
        .TAG_DATA_WIDTH(TW),
        .CNT_WIDTH(CW)
    ) dut (
        .sys_clk(clk),
        .sys_rst(rst),
        .alloc_req(req),
        .alloc_tag(tag),
        .alloc_ready(ready),
        .alloc_gnt(gnt),
        .alloc_ch(ch),
        .rel_val(relv),
        .rel_ch(relch),
        .rel_tag_val(rtv),
        .rel_tag(rtag),
        .free_cnt(fcnt),
        .err_double_free(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit      m_valid = 0;
    bit      m_run;
    int      m_init_left;
    bit      m_busy [N];
    int      m_tag  [N];
    int      m_rr, m_free;
    bit      m_err;
    bit      e_gnt, e_relv;
    int      e_ch, e_reltag;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1; m_run = 0; m_init_left = N;
            m_rr = 0; m_free = 0; m_err = 0;
            e_gnt = 0; e_relv = 0; e_ch = 0; e_reltag = 0;
        end else if (m_valid && !m_run) begin
            e_gnt = 0; e_relv = 0;
            m_init_left--;
            if (m_init_left == 0) begin
                m_run = 1; m_free = N;
                for (int k = 0; k < N; k++) begin m_busy[k] = 0; m_tag[k] = 0; end
            end
        end else if (m_valid) begin
            bit acc, rok;
            int sel;
            acc = req && (m_free != 0);
            rok = relv && (int'(relch) < N) && m_busy[relch];
            sel = -1;
            if (acc)
                for (int k = 0; k < N; k++)
                    if (sel < 0 && !m_busy[(m_rr + k) % N]) sel = (m_rr + k) % N;
            e_gnt = acc; e_relv = rok;
            if (rok) begin
                e_reltag = m_tag[relch]; m_busy[relch] = 0; m_free++;
            end else if (relv) m_err = 1;
            if (acc) begin
                e_ch = sel; m_busy[sel] = 1; m_tag[sel] = int'(tag);
                m_rr = (sel + 1) % N; m_free--;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_ready", int'(ready), int'(m_run && m_free != 0));
            chk("m_gnt", int'(gnt), int'(e_gnt));
            if (e_gnt) chk("m_ch", int'(ch), e_ch);
            chk("m_relv", int'(rtv), int'(e_relv));
            if (e_relv) chk("m_reltag", int'(rtag), e_reltag);
            chk("m_free", int'(fcnt), m_free);
            chk("m_err", int'(err), int'(m_err));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic rel_one(input int c, input int exp_tag);
        relv = 1; relch = W'(c); step(); relv = 0;
        chk("rel_pulse", int'(rtv), 1);
        chk("rel_tag", int'(rtag), exp_tag);
    endtask

    task automatic init_check();
        chk("init_ready0", int'(ready), 0);
        for (int i = 1; i < 64; i++) begin
            step();
            chk("init_ready0", int'(ready), 0);
        end
        step();
        chk("init_ready1", int'(ready), 1);
        chk("init_free", int'(fcnt), 64);
    endtask

    initial begin
        rst = 1; req = 0; tag = '0; relv = 0; relch = '0;
        step(); step();
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_free", int'(fcnt), 0);
        chk("rst_err", int'(err), 0);
        rst = 0;
        init_check();

        // 64 back-to-back grants in channel order
        for (int i = 0; i < 64; i++) begin
            req = 1; tag = TW'(32'h100 + i);
            step();
            chk("b2b_gnt", int'(gnt), 1);
            chk("b2b_ch", int'(ch), i);
        end
        chk("full_free", int'(fcnt), 0);
        chk("full_ready", int'(ready), 0);
        tag = 14'h200;
        step();
        chk("held_gnt", int'(gnt), 0);

        // release ch17 while the request is held
        rel_one(17, 'h111);
        chk("r17_free", int'(fcnt), 1);
        chk("r17_ready", int'(ready), 1);
        step();
        chk("r17_gnt", int'(gnt), 1);
        chk("r17_ch", int'(ch), 17);
        req = 0;

        // rr_ptr is 18: with 10 and 20 free, 20 wins, then 10 by wrap
        rel_one(10, 'h10A);
        rel_one(20, 'h114);
        req = 1; tag = 14'h210; step(); req = 0;
        chk("rr_ch20", int'(ch), 20);
        req = 1; tag = 14'h211; step(); req = 0;
        chk("rr_ch10", int'(ch), 10);

        // only ch40 free; accept and release ch5 in the same cycle
        rel_one(40, 'h128);
        req = 1; tag = 14'h300; relv = 1; relch = 6'd5;
        step();
        req = 0; relv = 0;
        chk("sim_gnt", int'(gnt), 1);
        chk("sim_ch", int'(ch), 40);
        chk("sim_rtag", int'(rtag), 'h105);
        chk("sim_free", int'(fcnt), 1);
        req = 1; tag = 14'h301; step(); req = 0;
        chk("wrap_ch5", int'(ch), 5);

        // double free of ch3
        rel_one(3, 'h103);
        relv = 1; relch = 6'd3; step(); relv = 0;
        chk("dbl_relv", int'(rtv), 0);
        chk("dbl_err", int'(err), 1);
        chk("dbl_free", int'(fcnt), 1);
        repeat (3) step();
        chk("dbl_sticky", int'(err), 1);

        // reset during a grant burst
        rel_one(0, 'h100);
        rel_one(1, 'h101);
        rel_one(2, 'h102);
        req = 1; tag = 14'h3AA;
        step(); step();
        rst = 1;
        step();
        req = 0;
        chk("mid_gnt", int'(gnt), 0);
        chk("mid_ch", int'(ch), 0);
        chk("mid_rtv", int'(rtv), 0);
        chk("mid_rtag", int'(rtag), 0);
        chk("mid_free", int'(fcnt), 0);
        chk("mid_err", int'(err), 0);
        chk("mid_ready", int'(ready), 0);
        rst = 0;
        init_check();
        req = 1; tag = 14'h3BB; step(); req = 0;
        chk("post_gnt", int'(gnt), 1);
        chk("post_ch", int'(ch), 0);
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
